// File: rtl/cpcs_rd_check_multi_if.sv
// Code-group input bundle and per-lane disparity status outputs of the
// CorePCS running-disparity checker.
interface cpcs_rd_check_multi_if #(
    parameter int LANES = 2,
    parameter int CNT_W = 16
);
    logic                IN_VALID;
    logic [10*LANES-1:0] DIN;
    logic                CNT_CLR;
    logic                OUT_VALID;
    logic [LANES-1:0]    DERR6;
    logic [LANES-1:0]    DERR4;
    logic [LANES-1:0]    CODE_ERR;
    logic [LANES-1:0]    RD_ERR;
    logic                RD_OUT;
    logic                LOCK;
    logic [CNT_W-1:0]    ERR_CNT;

    modport master (
        output IN_VALID, DIN, CNT_CLR,
        input  OUT_VALID, DERR6, DERR4, CODE_ERR, RD_ERR, RD_OUT, LOCK, ERR_CNT
    );

    modport slave (
        input  IN_VALID, DIN, CNT_CLR,
        output OUT_VALID, DERR6, DERR4, CODE_ERR, RD_ERR, RD_OUT, LOCK, ERR_CNT
    );
endinterface

// File: rtl/cpcs_rd_check_multi.sv
// Multi-lane registered 8B10B running-disparity checker with a saturating
// error counter and a disparity-lock state machine.
module cpcs_rd_check_multi #(
    parameter int LANES     = 2,
    parameter int CNT_W     = 16,
    parameter int GOOD_RUN  = 16,
    parameter int ERR_LIMIT = 4
) (
    input logic                  RBC1,
    input logic                  RESET,
    cpcs_rd_check_multi_if.slave bus
);
    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

    localparam int             SUM_W       = CNT_W + 1;
    localparam logic [7:0]     GOOD_RUN_8  = 8'(GOOD_RUN);
    localparam logic [7:0]     ERR_LIMIT_8 = 8'(ERR_LIMIT);
    localparam logic [SUM_W-1:0] CNT_MAX   = {1'b0, {CNT_W{1'b1}}};

    logic             rd_reg;
    logic             rd_chain [LANES+1];
    logic [LANES-1:0] derr6_comb, derr4_comb, code_err_comb, lane_err;
    logic             cycle_err;

    logic             out_valid_reg;
    logic [LANES-1:0] derr6_reg, derr4_reg, code_err_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [SUM_W-1:0] incr, err_sum;

    lock_state_t      state_reg, state_next;
    logic [7:0]       good_reg, good_next, bad_reg, bad_next, good_inc, bad_inc;
    logic             lock;

    assign rd_chain[0] = rd_reg;

    // Each lane starts from the disparity left by the previous lane.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [5:0] sb6;
        logic [3:0] sb4;
        logic [2:0] w6, w4;
        logic       rd6, need_minus6, need_plus6, need_minus4, need_plus4;

        assign sb6 = bus.DIN[10*gi+4 +: 6];
        assign sb4 = bus.DIN[10*gi +: 4];

        always_comb begin
            w6 = '0;
            for (int b = 0; b < 6; b++) w6 = w6 + 3'(sb6[b]);
            w4 = '0;
            for (int b = 0; b < 4; b++) w4 = w4 + 3'(sb4[b]);
        end

        assign need_minus6 = (w6 == 3'd4) || (sb6 == 6'b111000);
        assign need_plus6  = (w6 == 3'd2) || (sb6 == 6'b000111);
        assign rd6 = (w6 == 3'd4) ? 1'b1 : (w6 == 3'd2) ? 1'b0 : rd_chain[gi];

        assign need_minus4 = (w4 == 3'd3) || (sb4 == 4'b1100);
        assign need_plus4  = (w4 == 3'd1) || (sb4 == 4'b0011);
        assign rd_chain[gi+1] = (w4 == 3'd3) ? 1'b1 : (w4 == 3'd1) ? 1'b0 : rd6;

        assign derr6_comb[gi]    = (need_minus6 & rd_chain[gi]) | (need_plus6 & ~rd_chain[gi]);
        assign derr4_comb[gi]    = (need_minus4 & rd6) | (need_plus4 & ~rd6);
        assign code_err_comb[gi] = (w6 < 3'd2) || (w6 > 3'd4) || (w4 == 3'd0) || (w4 == 3'd4);
    end

    assign lane_err  = derr6_comb | derr4_comb | code_err_comb;
    assign cycle_err = |lane_err;

    always_comb begin
        incr = '0;
        if (bus.IN_VALID) begin
            for (int k = 0; k < LANES; k++) incr = incr + SUM_W'(lane_err[k]);
        end
    end

    assign err_sum = {1'b0, cnt_reg} + incr;

    always_comb begin
        cnt_next = cnt_reg;
        if (bus.CNT_CLR)          cnt_next = incr[CNT_W-1:0];
        else if (err_sum > CNT_MAX) cnt_next = CNT_MAX[CNT_W-1:0];
        else                      cnt_next = err_sum[CNT_W-1:0];
    end

    always_ff @(posedge RBC1) begin
        if (RESET) begin
            rd_reg        <= 1'b0;
            out_valid_reg <= 1'b0;
            derr6_reg     <= '0;
            derr4_reg     <= '0;
            code_err_reg  <= '0;
            cnt_reg       <= '0;
        end else begin
            out_valid_reg <= bus.IN_VALID;
            cnt_reg       <= cnt_next;
            if (bus.IN_VALID) begin
                rd_reg       <= rd_chain[LANES];
                derr6_reg    <= derr6_comb;
                derr4_reg    <= derr4_comb;
                code_err_reg <= code_err_comb;
            end else begin
                derr6_reg    <= '0;
                derr4_reg    <= '0;
                code_err_reg <= '0;
            end
        end
    end

    // Lock FSM: state register
    always_ff @(posedge RBC1) begin
        if (RESET) begin
            state_reg <= UNLOCKED;
            good_reg  <= '0;
            bad_reg   <= '0;
        end else begin
            state_reg <= state_next;
            good_reg  <= good_next;
            bad_reg   <= bad_next;
        end
    end

    assign good_inc = good_reg + 8'd1;
    assign bad_inc  = bad_reg + 8'd1;

    // Lock FSM: next state; invalid cycles leave everything untouched.
    always_comb begin
        state_next = state_reg;
        good_next  = good_reg;
        bad_next   = bad_reg;
        if (bus.IN_VALID) begin
            case (state_reg)
                UNLOCKED: begin
                    if (cycle_err) begin
                        good_next = '0;
                    end else if (good_inc == GOOD_RUN_8) begin
                        state_next = LOCKED;
                        good_next  = '0;
                        bad_next   = '0;
                    end else begin
                        good_next = good_inc;
                    end
                end
                LOCKED: begin
                    if (cycle_err) begin
                        good_next = '0;
                        if (bad_inc == ERR_LIMIT_8) begin
                            state_next = UNLOCKED;
                            bad_next   = '0;
                        end else begin
                            bad_next = bad_inc;
                        end
                    end else if (good_inc == GOOD_RUN_8) begin
                        good_next = '0;
                        bad_next  = '0;
                    end else begin
                        good_next = good_inc;
                    end
                end
                default: state_next = UNLOCKED;
            endcase
        end
    end

    // Lock FSM: outputs
    always_comb begin
        lock = 1'b0;
        if (state_reg == LOCKED) lock = 1'b1;
    end

    assign bus.OUT_VALID = out_valid_reg;
    assign bus.DERR6     = derr6_reg;
    assign bus.DERR4     = derr4_reg;
    assign bus.CODE_ERR  = code_err_reg;
    assign bus.RD_ERR    = derr6_reg | derr4_reg;
    assign bus.RD_OUT    = rd_reg;
    assign bus.LOCK      = lock;
    assign bus.ERR_CNT   = cnt_reg;
endmodule

// File: tb/tb_cpcs_rd_check_multi.sv
// Self-checking bench for cpcs_rd_check_multi: hand-derived vector table,
// directed lock/saturation/reset sequences and randomized model comparison.
module tb_cpcs_rd_check_multi;
    localparam int LANES = 2;
    localparam int DW    = 10 * LANES;

    localparam logic [9:0] KP  = 10'b0011111010;  // K28.5, legal at RD-, leaves RD+
    localparam logic [9:0] KN  = 10'b1100000101;  // K28.5, legal at RD+, leaves RD-
    localparam logic [9:0] CE  = 10'b1111110000;  // illegal weights in both sub-blocks
    localparam logic [9:0] NEU = 10'b1010101010;  // neutral, always legal

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpcs_rd_check_multi_if #(.LANES(LANES), .CNT_W(16)) bus ();
    cpcs_rd_check_multi_if #(.LANES(LANES), .CNT_W(4))  bus4 ();

    cpcs_rd_check_multi #(.LANES(LANES), .CNT_W(16), .GOOD_RUN(16), .ERR_LIMIT(4)) dut (
        .RBC1(clk), .RESET(rst), .bus(bus)
    );
    cpcs_rd_check_multi #(.LANES(LANES), .CNT_W(4), .GOOD_RUN(16), .ERR_LIMIT(4)) dut4 (
        .RBC1(clk), .RESET(rst), .bus(bus4)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state
    int         m_rd, m_cnt16, m_cnt4, m_good, m_bad;
    bit         m_lock;
    logic       e_ov;
    logic [1:0] e_d6, e_d4, e_ce;

    typedef struct {
        bit          v;
        logic [19:0] din;
        bit          clr;
        logic [1:0]  d6;
        logic [1:0]  d4;
        logic [1:0]  ce;
        bit          rd;
        int          cnt;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input logic [DW-1:0] d, input bit clr);
        int rd, w6, w4, nerr;
        logic [5:0] s6;
        logic [3:0] s4;
        logic [1:0] d6, d4, ce;
        if (r) begin
            m_rd = 0; m_cnt16 = 0; m_cnt4 = 0; m_good = 0; m_bad = 0; m_lock = 0;
            e_ov = 0; e_d6 = 0; e_d4 = 0; e_ce = 0;
            return;
        end
        rd = m_rd; d6 = 0; d4 = 0; ce = 0;
        for (int k = 0; k < LANES; k++) begin
            s6 = d[10*k+4 +: 6];
            s4 = d[10*k +: 4];
            w6 = $countones(s6);
            w4 = $countones(s4);
            if (w6 < 2 || w6 > 4)       ce[k] = 1'b1;
            else if (w6 == 4)           begin d6[k] = (rd == 1); rd = 1; end
            else if (w6 == 2)           begin d6[k] = (rd == 0); rd = 0; end
            else if (s6 == 6'b111000)   d6[k] = (rd == 1);
            else if (s6 == 6'b000111)   d6[k] = (rd == 0);
            if (w4 == 0 || w4 == 4)     ce[k] = 1'b1;
            else if (w4 == 3)           begin d4[k] = (rd == 1); rd = 1; end
            else if (w4 == 1)           begin d4[k] = (rd == 0); rd = 0; end
            else if (s4 == 4'b1100)     d4[k] = (rd == 1);
            else if (s4 == 4'b0011)     d4[k] = (rd == 0);
        end
        e_ov = v;
        if (v) begin
            e_d6 = d6; e_d4 = d4; e_ce = ce; m_rd = rd;
            nerr = $countones(d6 | d4 | ce);
        end else begin
            e_d6 = 0; e_d4 = 0; e_ce = 0;
            nerr = 0;
        end
        m_cnt16 = clr ? nerr : ((m_cnt16 + nerr > 65535) ? 65535 : m_cnt16 + nerr);
        m_cnt4  = clr ? nerr : ((m_cnt4 + nerr > 15) ? 15 : m_cnt4 + nerr);
        if (v) begin
            if (!m_lock) begin
                if (nerr > 0) m_good = 0;
                else begin
                    m_good++;
                    if (m_good == 16) begin m_lock = 1; m_good = 0; m_bad = 0; end
                end
            end else begin
                if (nerr > 0) begin
                    m_good = 0;
                    m_bad++;
                    if (m_bad == 4) begin m_lock = 0; m_bad = 0; end
                end else begin
                    m_good++;
                    if (m_good == 16) begin m_good = 0; m_bad = 0; end
                end
            end
        end
    endtask

    task automatic drive(input bit r, input bit v, input logic [DW-1:0] d, input bit clr);
        rst = r;
        bus.IN_VALID  = v; bus.DIN  = d; bus.CNT_CLR  = clr;
        bus4.IN_VALID = v; bus4.DIN = d; bus4.CNT_CLR = clr;
        @(posedge clk);
        #1;
        cyc++;
        model_step(r, v, d, clr);
        $display("cyc=%0d rst=%0b v=%0b din=%05h clr=%0b -> ov=%0b d6=%02b d4=%02b ce=%02b rd=%0b lock=%0b cnt=%0d cnt4=%0d",
                 cyc, r, v, d, clr, bus.OUT_VALID, bus.DERR6, bus.DERR4, bus.CODE_ERR,
                 bus.RD_OUT, bus.LOCK, bus.ERR_CNT, bus4.ERR_CNT);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_ov"},   32'(bus.OUT_VALID), 32'(e_ov));
        chk({tag, "_d6"},   32'(bus.DERR6),     32'(e_d6));
        chk({tag, "_d4"},   32'(bus.DERR4),     32'(e_d4));
        chk({tag, "_ce"},   32'(bus.CODE_ERR),  32'(e_ce));
        chk({tag, "_rde"},  32'(bus.RD_ERR),    32'(e_d6 | e_d4));
        chk({tag, "_rd"},   32'(bus.RD_OUT),    32'(m_rd));
        chk({tag, "_lock"}, 32'(bus.LOCK),      32'(m_lock));
        chk({tag, "_cnt"},  32'(bus.ERR_CNT),   32'(m_cnt16));
        chk({tag, "_cnt4"}, 32'(bus4.ERR_CNT),  32'(m_cnt4));
    endtask

    function automatic logic [DW-1:0] clean_word(input int rd0, input int sel);
        logic [DW-1:0] w;
        int rd;
        rd = rd0;
        w  = '0;
        for (int k = 0; k < LANES; k++) begin
            if (((sel >> k) & 1) == 1) begin
                w[10*k +: 10] = (rd == 1) ? KN : KP;
                rd = 1 - rd;
            end else begin
                w[10*k +: 10] = NEU;
            end
        end
        return w;
    endfunction

    // Lane 0 carries a K28.5 of the wrong disparity, lane 1 is neutral.
    function automatic logic [DW-1:0] err_word(input int rd0);
        return {NEU, (rd0 == 1) ? KP : KN};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, {KN, KP},                     1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 0};
        tbl[1] = '{1'b1, {KP, KP},                     1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 1};
        tbl[2] = '{1'b1, {NEU, CE},                    1'b0, 2'b00, 2'b00, 2'b01, 1'b1, 2};
        tbl[3] = '{1'b0, {KP, KP},                     1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2};
        tbl[4] = '{1'b1, {KP, KP},                     1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 4};
        tbl[5] = '{1'b1, {10'b1110001100, KN},         1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 4};
        tbl[6] = '{1'b1, {10'b1010101110, 10'b0001110011}, 1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 5};
        tbl[7] = '{1'b1, {10'b1010100001, 10'b1010101110}, 1'b1, 2'b00, 2'b01, 2'b00, 1'b0, 1};

        // Reset state
        drive(1, 1, {KP, KP}, 1);
        drive(1, 0, '0, 0);
        chk("rst_ov",   32'(bus.OUT_VALID), 0);
        chk("rst_d6",   32'(bus.DERR6),     0);
        chk("rst_d4",   32'(bus.DERR4),     0);
        chk("rst_ce",   32'(bus.CODE_ERR),  0);
        chk("rst_rde",  32'(bus.RD_ERR),    0);
        chk("rst_rd",   32'(bus.RD_OUT),    0);
        chk("rst_lock", 32'(bus.LOCK),      0);
        chk("rst_cnt",  32'(bus.ERR_CNT),   0);

        // Table of hand-derived vectors
        for (int i = 0; i < 8; i++) begin
            drive(0, tbl[i].v, tbl[i].din, tbl[i].clr);
            chk("tbl_ov",  32'(bus.OUT_VALID), 32'(tbl[i].v));
            chk("tbl_d6",  32'(bus.DERR6),     32'(tbl[i].d6));
            chk("tbl_d4",  32'(bus.DERR4),     32'(tbl[i].d4));
            chk("tbl_ce",  32'(bus.CODE_ERR),  32'(tbl[i].ce));
            chk("tbl_rde", 32'(bus.RD_ERR),    32'(tbl[i].d6 | tbl[i].d4));
            chk("tbl_rd",  32'(bus.RD_OUT),    32'(tbl[i].rd));
            chk("tbl_cnt", 32'(bus.ERR_CNT),   32'(tbl[i].cnt));
        end

        // Clean K28.5 pairs: LOCK rises on the output of the 16th input
        drive(1, 0, '0, 0);
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, {KN, KP}, 0);
            chk("lk_lock", 32'(bus.LOCK),    (i >= 15) ? 32'd1 : 32'd0);
            chk("lk_rd",   32'(bus.RD_OUT),  0);
            chk("lk_cnt",  32'(bus.ERR_CNT), 0);
            chk("lk_d6",   32'(bus.DERR6),   0);
        end

        // Errors spaced by 16 clean cycles keep the lock
        for (int j = 0; j < 5; j++) begin
            drive(0, 1, err_word(m_rd), 0);
            chk("keep_lock_err", 32'(bus.LOCK), 1);
            for (int i = 0; i < 16; i++) begin
                drive(0, 1, clean_word(m_rd, int'($urandom_range(0, 3))), 0);
                chk("keep_lock_clean", 32'(bus.LOCK), 1);
            end
        end

        // Four errors closer than 16 clean cycles drop the lock on the 4th
        for (int j = 0; j < 4; j++) begin
            drive(0, 1, err_word(m_rd), 0);
            chk("drop_lock", 32'(bus.LOCK), (j < 3) ? 32'd1 : 32'd0);
            if (j < 3) begin
                for (int i = 0; i < 5; i++) begin
                    drive(0, 1, clean_word(m_rd, int'($urandom_range(0, 3))), 0);
                    chk("drop_lock_gap", 32'(bus.LOCK), 1);
                end
            end
        end

        // 4-bit counter saturation, then clear-and-count
        drive(1, 0, '0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, {CE, CE}, 0);
            chk("sat_cnt4", 32'(bus4.ERR_CNT), (2 * (i + 1) > 15) ? 32'd15 : 32'(2 * (i + 1)));
            chk("sat_cnt16", 32'(bus.ERR_CNT), 32'(2 * (i + 1)));
        end
        drive(0, 1, err_word(m_rd), 1);
        chk("clr_cnt4",  32'(bus4.ERR_CNT), 1);
        chk("clr_cnt16", 32'(bus.ERR_CNT),  1);

        // Reset mid-stream while locked at RD+
        drive(1, 0, '0, 0);
        for (int i = 0; i < 16; i++) drive(0, 1, {KN, KP}, 0);
        drive(0, 1, {NEU, KP}, 0);
        chk("mid_pre_rd",   32'(bus.RD_OUT), 1);
        chk("mid_pre_lock", 32'(bus.LOCK),   1);
        drive(1, 1, {KP, KP}, 1);
        chk("mid_rst_rd",   32'(bus.RD_OUT),    0);
        chk("mid_rst_lock", 32'(bus.LOCK),      0);
        chk("mid_rst_ov",   32'(bus.OUT_VALID), 0);
        chk("mid_rst_cnt",  32'(bus.ERR_CNT),   0);
        drive(0, 1, {NEU, KP}, 0);
        chk("mid_post_d6", 32'(bus.DERR6),  0);
        chk("mid_post_rd", 32'(bus.RD_OUT), 1);

        // Randomized run against the reference model
        for (int i = 0; i < 400; i++) begin
            int sel;
            logic [DW-1:0] d;
            sel = int'($urandom_range(0, 99));
            if (sel < 10)      d = DW'($urandom);
            else if (sel < 20) d = err_word(m_rd);
            else               d = clean_word(m_rd, int'($urandom_range(0, 3)));
            drive(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
                  d,
                  ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
            check_model("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
